// File: rtl/hilo_sequencer.sv
// Sequences the multi-cycle multiply/divide units and the HI/LO write for MULT/DIV-class ops.
// One request at a time: issue pulse, latency count, then write or divide-by-zero exception.
module hilo_sequencer #(
   parameter int unsigned MULT_LAT = 32,
   parameter int unsigned DIV_LAT  = 32,
   parameter int unsigned CNT_W    = 6
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic op,
   input  logic src_mem,
   input  logic abort,
   input  logic div_by_zero,
   output logic multOP,
   output logic divOP,
   output logic mem_a,
   output logic mem_b,
   output logic mult_div_sel,
   output logic hilo_write,
   output logic busy,
   output logic done,
   output logic div_zero_exc
);

   typedef enum logic [2:0] {StIdle, StIssue, StWait, StWrite, StExc} state_e;

   localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_LAT - 1);
   localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_LAT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             op_q, op_d;
   logic             mem_q, mem_d;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         op_q    <= 1'b0;
         mem_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         mem_q   <= mem_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      mem_d   = mem_q;
      unique case (state_q)
         StIdle: begin
            if (start && !abort) begin
               op_d    = op;
               mem_d   = src_mem;
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (abort) begin
               state_d = StIdle;
            end else begin
               cnt_d   = op_q ? DivLoad : MultLoad;
               state_d = StWait;
            end
         end
         StWait: begin
            // Abort beats a zero divisor, which beats counter expiry.
            if (abort) begin
               state_d = StIdle;
            end else if (op_q && div_by_zero) begin
               state_d = StExc;
            end else if (cnt_q == '0) begin
               state_d = StWrite;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StWrite: state_d = StIdle;
         StExc:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs are decoded from state and latched request only, never from start.
   always_comb begin
      busy         = (state_q != StIdle);
      multOP       = (state_q == StIssue) && !op_q;
      divOP        = (state_q == StIssue) && op_q;
      mem_a        = busy && mem_q;
      mem_b        = busy && mem_q;
      mult_div_sel = busy && op_q;
      hilo_write   = (state_q == StWrite);
      done         = (state_q == StWrite);
      div_zero_exc = (state_q == StExc);
   end

endmodule

// File: tb/tb_hilo_sequencer.sv
// Directed bench for hilo_sequencer: default latencies on one instance, MULT_LAT=1/DIV_LAT=3 on
// a second instance sharing the same stimulus.
module tb_hilo_sequencer;

   localparam logic [8:0] MULT = 9'h100;
   localparam logic [8:0] DIV  = 9'h080;
   localparam logic [8:0] MA   = 9'h040;
   localparam logic [8:0] MB   = 9'h020;
   localparam logic [8:0] SEL  = 9'h010;
   localparam logic [8:0] HW   = 9'h008;
   localparam logic [8:0] BUSY = 9'h004;
   localparam logic [8:0] DONE = 9'h002;
   localparam logic [8:0] EXC  = 9'h001;
   localparam logic [8:0] NONE = 9'h000;

   logic clk, reset, start, op, src_mem, abort, div_by_zero;
   logic a_mult, a_div, a_ma, a_mb, a_sel, a_hw, a_busy, a_done, a_exc;
   logic b_mult, b_div, b_ma, b_mb, b_sel, b_hw, b_busy, b_done, b_exc;
   logic [8:0] av, bv, e;
   int checks = 0;
   int failures = 0;

   hilo_sequencer u_dut_a (
      .clk(clk), .reset(reset), .start(start), .op(op), .src_mem(src_mem), .abort(abort),
      .div_by_zero(div_by_zero), .multOP(a_mult), .divOP(a_div), .mem_a(a_ma), .mem_b(a_mb),
      .mult_div_sel(a_sel), .hilo_write(a_hw), .busy(a_busy), .done(a_done),
      .div_zero_exc(a_exc)
   );

   hilo_sequencer #(.MULT_LAT(1), .DIV_LAT(3), .CNT_W(6)) u_dut_b (
      .clk(clk), .reset(reset), .start(start), .op(op), .src_mem(src_mem), .abort(abort),
      .div_by_zero(div_by_zero), .multOP(b_mult), .divOP(b_div), .mem_a(b_ma), .mem_b(b_mb),
      .mult_div_sel(b_sel), .hilo_write(b_hw), .busy(b_busy), .done(b_done),
      .div_zero_exc(b_exc)
   );

   assign av = {a_mult, a_div, a_ma, a_mb, a_sel, a_hw, a_busy, a_done, a_exc};
   assign bv = {b_mult, b_div, b_ma, b_mb, b_sel, b_hw, b_busy, b_done, b_exc};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b0; start = 1'b1; op = 1'b0; src_mem = 1'b0; abort = 1'b0; div_by_zero = 1'b0;

      // Reset held with start asserted.
      tick; chk("rst_c1", av, NONE);
      tick; chk("rst_c2", av, NONE); chk("rst_c2_b", bv, NONE);
      reset = 1'b1; start = 1'b0;
      tick; chk("post_rst_1", av, NONE);
      tick; chk("post_rst_2", av, NONE);

      // Multiply, with an ignored start at N+5 and an ignored div_by_zero at N+10.
      op = 1'b0; src_mem = 1'b0; start = 1'b1;
      tick; start = 1'b0;
      for (int k = 1; k <= 34; k++) begin
         e = BUSY;
         if (k == 1) e = e | MULT;
         if (k == 34) e = e | HW | DONE;
         chk($sformatf("mult_k%0d", k), av, e);
         start = (k == 5);
         div_by_zero = (k == 10);
         tick;
      end
      start = 1'b0; div_by_zero = 1'b0;
      chk("mult_idle_n35", av, NONE);
      start = 1'b1;
      tick; start = 1'b0;
      chk("restart_issue_n36", av, MULT | BUSY);
      abort = 1'b1;
      tick; abort = 1'b0;
      chk("abort_in_issue", av, NONE);

      // Divide by zero raised at N+5.
      op = 1'b1; src_mem = 1'b0; start = 1'b1;
      tick; start = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         if (k == 1)      e = DIV | SEL | BUSY;
         else if (k <= 5) e = SEL | BUSY;
         else if (k == 6) e = SEL | BUSY | EXC;
         else             e = NONE;
         chk($sformatf("dbz_k%0d", k), av, e);
         div_by_zero = (k == 5);
         tick;
      end
      div_by_zero = 1'b0;

      // Abort during WAIT with memory operands.
      op = 1'b1; src_mem = 1'b1; start = 1'b1;
      tick; start = 1'b0;
      for (int k = 1; k <= 11; k++) begin
         if (k == 1)       e = DIV | MA | MB | SEL | BUSY;
         else if (k <= 10) e = MA | MB | SEL | BUSY;
         else              e = NONE;
         chk($sformatf("abort_k%0d", k), av, e);
         abort = (k == 10);
         tick;
      end
      abort = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("abort_quiet_%0d", k), av, NONE);
         tick;
      end

      // Reset mid-operation discards it.
      op = 1'b1; src_mem = 1'b0; start = 1'b1;
      tick; start = 1'b0;
      chk("midrst_k1", av, DIV | SEL | BUSY);
      tick; chk("midrst_k2", av, SEL | BUSY);
      tick; chk("midrst_k3", av, SEL | BUSY);
      reset = 1'b0;
      tick; reset = 1'b1;
      chk("midrst_k4", av, NONE);
      chk("midrst_k4_b", bv, NONE);
      for (int k = 0; k < 3; k++) begin
         tick;
         chk($sformatf("midrst_quiet_%0d", k), av, NONE);
      end

      // Short latencies (instance b); abort during WRITE is ignored.
      op = 1'b0; src_mem = 1'b0; start = 1'b1;
      tick; start = 1'b0;
      chk("b_mult_k1", bv, MULT | BUSY);
      tick; chk("b_mult_k2", bv, BUSY);
      tick; chk("b_mult_k3", bv, HW | BUSY | DONE);
      abort = 1'b1;
      tick; abort = 1'b0;
      chk("b_mult_k4", bv, NONE);

      op = 1'b1; src_mem = 1'b1; start = 1'b1;
      tick; start = 1'b0;
      chk("b_div_k1", bv, DIV | MA | MB | SEL | BUSY);
      tick; chk("b_div_k2", bv, MA | MB | SEL | BUSY);
      tick; chk("b_div_k3", bv, MA | MB | SEL | BUSY);
      tick; chk("b_div_k4", bv, MA | MB | SEL | BUSY);
      tick; chk("b_div_k5", bv, MA | MB | SEL | HW | BUSY | DONE);
      tick; chk("b_div_k6", bv, NONE);
      // Back-to-back: start in the first IDLE cycle after done.
      op = 1'b0; src_mem = 1'b0; start = 1'b1;
      tick; start = 1'b0;
      chk("b_b2b_k7", bv, MULT | BUSY);
      tick; chk("b_b2b_k8", bv, BUSY);
      tick; chk("b_b2b_k9", bv, HW | BUSY | DONE);
      tick; chk("b_b2b_k10", bv, NONE);

      // start together with abort in IDLE is dropped.
      start = 1'b1; abort = 1'b1;
      tick; start = 1'b0; abort = 1'b0;
      chk("b_start_abort_1", bv, NONE);
      chk("a_start_abort_1", av, NONE);
      tick; chk("b_start_abort_2", bv, NONE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
